// File: rtl/rat_int_ctrl_if.sv
// rat_int_ctrl_if : port-bus and interrupt handshake bundle between the RAT CPU
// (plus its peripheral IRQ lines) and the rat_int_ctrl interrupt controller.
//
// Signals:
//   IRQ      peripheral interrupt requests, active-high, NUM_CH wide
//   IO_STRB  CPU output strobe, one cycle per OUT instruction
//   PORT_ID  CPU port address
//   OUT_PORT CPU write data
//   RD_DATA  controller read data for the IN_PORT mux (combinational from PORT_ID)
//   RD_HIT   PORT_ID lies inside the controller register window
//   INT      registered interrupt request to the CPU
//   INT_ACK  one-cycle pulse from the CPU when it enters its interrupt cycle
//
// Modports: master = CPU / peripheral side, slave = controller side.
interface rat_int_ctrl_if #(
   parameter int NUM_CH = 8
);
   logic [NUM_CH-1:0] IRQ;
   logic              IO_STRB;
   logic [7:0]        PORT_ID;
   logic [7:0]        OUT_PORT;
   logic [7:0]        RD_DATA;
   logic              RD_HIT;
   logic              INT;
   logic              INT_ACK;

   modport master (
      output IRQ, IO_STRB, PORT_ID, OUT_PORT, INT_ACK,
      input  RD_DATA, RD_HIT, INT
   );

   modport slave (
      input  IRQ, IO_STRB, PORT_ID, OUT_PORT, INT_ACK,
      output RD_DATA, RD_HIT, INT
   );
endinterface

// File: rtl/rat_int_ctrl.sv
// rat_int_ctrl : NUM_CH-source prioritised, maskable interrupt controller for the
// RAT CPU. Channel 0 has the highest priority. Configured and serviced through a
// 4-register port window at BASE_ID..BASE_ID+3:
//   +0 MASK  r/w  bit n enables channel n
//   +1 MODE  r/w  bit n = 1 edge mode, 0 level mode
//   +2 PEND  r    write-1-to-clear on edge channels only
//   +3 VEC   r    captured vector; any write is end-of-interrupt (EOI)
//
// Ports:
//   CLK    system clock
//   RESET  synchronous, active-high; clears every register including mid-service
//   bus    rat_int_ctrl_if.slave (IRQ, IO_STRB, PORT_ID, OUT_PORT, INT_ACK in;
//          RD_DATA, RD_HIT, INT out)
//
// Build option: define RAT_INT_SYNC_EN to pass IRQ through a 2-flop synchroniser
// (request-to-INT latency 4 cycles, IRQ may be asynchronous). Without it IRQ must
// be synchronous to CLK and the latency is 2 cycles.
module rat_int_ctrl #(
   parameter int         NUM_CH  = 8,
   parameter logic [7:0] BASE_ID = 8'hF0
) (
   input logic           CLK,
   input logic           RESET,
   rat_int_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ASSERT  = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   // Bits at or above NUM_CH are held at zero everywhere.
   localparam logic [7:0] CH_MASK = 8'((9'd1 << NUM_CH) - 9'd1);

   logic [7:0] mask_q, mask_d;
   logic [7:0] mode_q, mode_d;
   logic [7:0] pend_q, pend_d;
   logic [7:0] vec_q,  vec_d;
   logic [7:0] irq_q,  irq_d;
   state_t     state_q, state_d;
   logic       int_q,   int_d;

   logic [7:0] irq_in;
   logic [7:0] offset;
   logic       hit;
   logic       wr_mask, wr_mode, wr_pend, wr_vec;
   logic [7:0] w1c;
   logic [7:0] edge_set;
   logic [7:0] act;
   logic [2:0] sel;
   logic [7:0] ack_clr;
   logic       ack_take;

`ifdef RAT_INT_SYNC_EN
   logic [7:0] sync1_q, sync2_q;
   assign irq_in = sync2_q;
`else
   assign irq_in = 8'(bus.IRQ) & CH_MASK;
`endif

   // Modular offset keeps the window correct even if it wraps past 8'hFF.
   assign offset  = bus.PORT_ID - BASE_ID;
   assign hit     = (offset[7:2] == 6'd0);
   assign wr_mask = bus.IO_STRB && hit && (offset[1:0] == 2'd0);
   assign wr_mode = bus.IO_STRB && hit && (offset[1:0] == 2'd1);
   assign wr_pend = bus.IO_STRB && hit && (offset[1:0] == 2'd2);
   assign wr_vec  = bus.IO_STRB && hit && (offset[1:0] == 2'd3);

   always_comb begin
      mask_d   = wr_mask ? (bus.OUT_PORT & CH_MASK) : mask_q;
      mode_d   = wr_mode ? (bus.OUT_PORT & CH_MASK) : mode_q;
      w1c      = wr_pend ? (bus.OUT_PORT & mode_q & CH_MASK) : 8'h00;
      edge_set = irq_in & ~irq_q & mode_q;
      irq_d    = irq_in;

      // A MASK write or W1C landing in this cycle already counts for arbitration,
      // so masking in the same cycle as INT_ACK yields a spurious vector.
      act = pend_q & ~w1c & mask_d;

      sel = 3'd0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (act[i]) sel = 3'(i);
      end

      ack_take = (state_q == S_ASSERT) && bus.INT_ACK && (act != 8'h00);
      ack_clr  = 8'h00;
      if (ack_take && mode_q[sel]) ack_clr[sel] = 1'b1;

      // Edge channels latch until cleared (a new edge beats a clear); level
      // channels simply follow the registered request.
      pend_d = ((mode_q & ((pend_q & ~w1c & ~ack_clr) | edge_set)) |
                (~mode_q & irq_in)) & CH_MASK;

      state_d = state_q;
      vec_d   = vec_q;
      case (state_q)
         S_IDLE: begin
            if (act != 8'h00) state_d = S_ASSERT;
         end
         S_ASSERT: begin
            if (bus.INT_ACK) begin
               vec_d   = ack_take ? {5'd0, sel} : 8'hFF;
               state_d = ack_take ? S_SERVICE : S_IDLE;
            end else if (act == 8'h00) begin
               state_d = S_IDLE;
            end
         end
         S_SERVICE: begin
            if (wr_vec) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      int_d = (state_d == S_ASSERT);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         mask_q  <= 8'h00;
         mode_q  <= 8'h00;
         pend_q  <= 8'h00;
         vec_q   <= 8'hFF;
         irq_q   <= 8'h00;
         state_q <= S_IDLE;
         int_q   <= 1'b0;
`ifdef RAT_INT_SYNC_EN
         sync1_q <= 8'h00;
         sync2_q <= 8'h00;
`endif
      end else begin
         mask_q  <= mask_d;
         mode_q  <= mode_d;
         pend_q  <= pend_d;
         vec_q   <= vec_d;
         irq_q   <= irq_d;
         state_q <= state_d;
         int_q   <= int_d;
`ifdef RAT_INT_SYNC_EN
         sync1_q <= 8'(bus.IRQ) & CH_MASK;
         sync2_q <= sync1_q;
`endif
      end
   end

   always_comb begin
      bus.RD_DATA = 8'h00;
      if (hit) begin
         case (offset[1:0])
            2'd0:    bus.RD_DATA = mask_q;
            2'd1:    bus.RD_DATA = mode_q;
            2'd2:    bus.RD_DATA = pend_q;
            default: bus.RD_DATA = vec_q;
         endcase
      end
   end

   assign bus.RD_HIT = hit;
   assign bus.INT    = int_q;

endmodule

// File: tb/tb_rat_int_ctrl.sv
// tb_rat_int_ctrl : directed self-checking bench for rat_int_ctrl (NUM_CH=8,
// BASE_ID=F0). Inputs change 1 time unit after a rising edge and outputs are
// sampled there as well.
module tb_rat_int_ctrl;

`ifdef RAT_INT_SYNC_EN
   localparam int SD = 2;
`else
   localparam int SD = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   logic [7:0] rv;
   logic [7:0] hv;

   rat_int_ctrl_if #(.NUM_CH(8)) bus ();

   rat_int_ctrl #(.NUM_CH(8), .BASE_ID(8'hF0)) dut (
      .CLK  (clk),
      .RESET(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s obs=%02h exp=%02h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      bus.IO_STRB  = 1'b1;
      bus.PORT_ID  = addr;
      bus.OUT_PORT = data;
      tick();
      bus.IO_STRB  = 1'b0;
      bus.PORT_ID  = 8'h00;
      bus.OUT_PORT = 8'h00;
   endtask

   task automatic rd(input logic [7:0] addr, output logic [7:0] data, output logic [7:0] h);
      bus.PORT_ID = addr;
      #1;
      data = bus.RD_DATA;
      h    = {7'd0, bus.RD_HIT};
      bus.PORT_ID = 8'h00;
   endtask

   task automatic ack();
      bus.INT_ACK = 1'b1;
      tick();
      bus.INT_ACK = 1'b0;
   endtask

   initial begin
      bus.IRQ      = 8'h00;
      bus.IO_STRB  = 1'b0;
      bus.PORT_ID  = 8'h00;
      bus.OUT_PORT = 8'h00;
      bus.INT_ACK  = 1'b0;
      rst = 1'b1;
      ticks(2);
      rst = 1'b0;
      tick();

      // Reset values and window decode
      rd(8'hF0, rv, hv); check("rst_mask", rv, 8'h00); check("rst_hit", hv, 8'h01);
      rd(8'hF1, rv, hv); check("rst_mode", rv, 8'h00);
      rd(8'hF2, rv, hv); check("rst_pend", rv, 8'h00);
      rd(8'hF3, rv, hv); check("rst_vec", rv, 8'hFF);
      check("rst_int", {7'd0, bus.INT}, 8'h00);
      rd(8'hF4, rv, hv); check("miss_data", rv, 8'h00); check("miss_hit", hv, 8'h00);

      // Single edge request on channel 3
      wr(8'hF0, 8'hFF);
      wr(8'hF1, 8'hFF);
      rd(8'hF0, rv, hv); check("mask_wr", rv, 8'hFF);
      bus.IRQ = 8'h08;
      tick();
      bus.IRQ = 8'h00;
      ticks(SD);
      rd(8'hF2, rv, hv); check("s2_pend_set", rv, 8'h08);
      check("s2_int_early", {7'd0, bus.INT}, 8'h00);
      tick();
      check("s2_int_assert", {7'd0, bus.INT}, 8'h01);
      ack();
      rd(8'hF3, rv, hv); check("s2_vec", rv, 8'h03);
      rd(8'hF2, rv, hv); check("s2_pend_clr", rv, 8'h00);
      check("s2_int_svc", {7'd0, bus.INT}, 8'h00);
      wr(8'hF3, 8'h00);
      check("s2_int_eoi", {7'd0, bus.INT}, 8'h00);
      tick();
      check("s2_int_idle", {7'd0, bus.INT}, 8'h00);

      // Two simultaneous edges: priority at ACK, then the leftover after EOI
      bus.IRQ = 8'h24;
      tick();
      bus.IRQ = 8'h00;
      ticks(SD);
      tick();
      check("s3_int", {7'd0, bus.INT}, 8'h01);
      ack();
      rd(8'hF3, rv, hv); check("s3_vec1", rv, 8'h02);
      rd(8'hF2, rv, hv); check("s3_pend1", rv, 8'h20);
      wr(8'hF3, 8'h00);
      check("s3_int_eoi", {7'd0, bus.INT}, 8'h00);
      tick();
      check("s3_int_re", {7'd0, bus.INT}, 8'h01);
      ack();
      rd(8'hF3, rv, hv); check("s3_vec2", rv, 8'h05);
      rd(8'hF2, rv, hv); check("s3_pend2", rv, 8'h00);
      wr(8'hF3, 8'h00);

      // Level channel 0 held high: re-request after EOI, then drop
      wr(8'hF1, 8'h00);
      wr(8'hF0, 8'h01);
      bus.IRQ = 8'h01;
      tick();
      ticks(SD);
      tick();
      check("s4_int", {7'd0, bus.INT}, 8'h01);
      ack();
      rd(8'hF3, rv, hv); check("s4_vec", rv, 8'h00);
      rd(8'hF2, rv, hv); check("s4_pend_lvl", rv, 8'h01);
      check("s4_int_svc", {7'd0, bus.INT}, 8'h00);
      wr(8'hF3, 8'h00);
      tick();
      check("s4_int_re", {7'd0, bus.INT}, 8'h01);
      bus.IRQ = 8'h00;
      ticks(2 + SD);
      check("s4_int_drop", {7'd0, bus.INT}, 8'h00);
      rd(8'hF2, rv, hv); check("s4_pend_drop", rv, 8'h00);

      // MASK=00 written in the ACK cycle gives a spurious vector and IDLE
      wr(8'hF1, 8'hFF);
      wr(8'hF0, 8'hFF);
      bus.IRQ = 8'h02;
      tick();
      bus.IRQ = 8'h00;
      ticks(SD);
      tick();
      check("s5_int", {7'd0, bus.INT}, 8'h01);
      bus.IO_STRB  = 1'b1;
      bus.PORT_ID  = 8'hF0;
      bus.OUT_PORT = 8'h00;
      bus.INT_ACK  = 1'b1;
      tick();
      bus.IO_STRB  = 1'b0;
      bus.PORT_ID  = 8'h00;
      bus.INT_ACK  = 1'b0;
      rd(8'hF3, rv, hv); check("s5_vec_spur", rv, 8'hFF);
      rd(8'hF2, rv, hv); check("s5_pend_kept", rv, 8'h02);
      check("s5_int_low", {7'd0, bus.INT}, 8'h00);
      wr(8'hF0, 8'hFF);
      check("s5_idle_reassert", {7'd0, bus.INT}, 8'h01);
      ack();
      rd(8'hF3, rv, hv); check("s5_vec", rv, 8'h01);
      wr(8'hF3, 8'h00);

      // W1C racing a new edge on the same bit: the set wins
      wr(8'hF0, 8'h00);
      bus.IRQ = 8'h10;
      tick();
      bus.IRQ = 8'h00;
      ticks(SD + 1);
      rd(8'hF2, rv, hv); check("s5_pend_b4", rv, 8'h10);
      bus.IRQ = 8'h10;
      ticks(SD);
      wr(8'hF2, 8'h10);
      bus.IRQ = 8'h00;
      rd(8'hF2, rv, hv); check("s5_w1c_race", rv, 8'h10);
      ticks(SD + 1);
      wr(8'hF2, 8'h10);
      rd(8'hF2, rv, hv); check("s5_w1c", rv, 8'h00);

      // Reset in SERVICE with PEND=0F
      wr(8'hF0, 8'hFF);
      bus.IRQ = 8'h0F;
      tick();
      bus.IRQ = 8'h00;
      ticks(SD);
      tick();
      check("s6_int", {7'd0, bus.INT}, 8'h01);
      ack();
      rd(8'hF3, rv, hv); check("s6_vec", rv, 8'h00);
      bus.IRQ = 8'h01;
      tick();
      bus.IRQ = 8'h00;
      ticks(SD);
      rd(8'hF2, rv, hv); check("s6_pend", rv, 8'h0F);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rd(8'hF0, rv, hv); check("s6_mask", rv, 8'h00);
      rd(8'hF1, rv, hv); check("s6_mode", rv, 8'h00);
      rd(8'hF2, rv, hv); check("s6_pend_rst", rv, 8'h00);
      rd(8'hF3, rv, hv); check("s6_vec_rst", rv, 8'hFF);
      check("s6_int_rst", {7'd0, bus.INT}, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
